memory_arbiter: RTL and testbench
=================================

// Module: memory_arbiter
// PURPOSE
//  Shares the single-port RAM between the icache (instruction fetch) and the dcache (loads, stores, block fill/writeback).
//  Sits between the caches and the RAM model; it arbitrates and sequences accesses and returns wait/load to the winning requester.
//  Grants are held across a multi-word burst so a dcache two-word block fill or writeback completes without interleaving.
// PARAMETERS
//  BURST_MAX     2   max consecutive words one owner may complete per grant before re-arbitration (>=1)
//  STARVE_LIMIT  4   consecutive dcache grants while iREN pending before icache is forced to win (MEMARB_STARVE_GUARD_EN only)
// PORTS
//  CLK       in   1   clock, rising edge
//  nRST      in   1   reset, asynchronous, active-low
//  iREN      in   1   icache read request
//  iaddr     in   32  icache word address
//  iwait     out  1   0 = icache access completes this cycle
//  iload     out  32  icache read data, valid when iwait==0
//  dREN      in   1   dcache read request
//  dWEN      in   1   dcache write request
//  daddr     in   32  dcache word address
//  dstore    in   32  dcache write data
//  dwait     out  1   0 = dcache access completes this cycle
//  dload     out  32  dcache read data, valid when dwait==0 and dREN
//  ramREN    out  1   RAM read enable
//  ramWEN    out  1   RAM write enable
//  ramaddr   out  32  RAM address
//  ramstore  out  32  RAM write data
//  ramload   in   32  RAM read data
//  ramstate  in   2   ramstate_t: FREE, BUSY, ACCESS, ERROR
// BEHAVIOUR
//  Clock/reset decided: one clock CLK; nRST asynchronous, active-low.
//  FSM states (arb_state_t): IDLE, IGRANT, DGRANT; registered owner + burst counter (clog2(BURST_MAX+1) bits).
//  Reset: state=IDLE, burst=0; iwait=1, dwait=1, iload=0, dload=0, ramREN=0, ramWEN=0, ramaddr=0, ramstore=0.
//  IDLE: no RAM enables, both waits 1. Next: (dREN|dWEN) -> DGRANT; else iREN -> IGRANT; else IDLE. Arbitration latency 1 cycle.
//  Simultaneous i+d request in IDLE: dcache wins (fixed priority).
//  DGRANT: ramaddr=daddr, ramstore=dstore; dWEN -> ramWEN=1, else ramREN=dREN. dWEN&dREN together: write wins, ramREN=0.
//  IGRANT: ramaddr=iaddr, ramREN=1, ramWEN=0, ramstore=0.
//  Completion: owner's wait=0 only in cycle ramstate==ACCESS; non-owner wait=1 always. Loads forward ramload combinationally when the owner's wait=0, else 0.
//  On completion burst+1; if owner still requesting and burst+1<BURST_MAX stay granted, else -> IDLE, burst=0.
//  Owner drops request while granted (no ACCESS that cycle): -> IDLE next cycle, RAM enables follow owner's request (0).
//  ramstate BUSY/FREE: hold state, wait=1. ERROR: hold state, wait=1 (no retry logic; RAM model owns recovery).
//  nRST asserted mid-burst: immediate return to reset values; partial burst abandoned.
// CONFIGURATION
//  MEMARB_STARVE_GUARD_EN defined: counter of consecutive dcache grants with iREN high at grant time;
//   at STARVE_LIMIT the next IDLE arbitration picks icache even if dcache requests; counter clears on any IGRANT or when iREN low.
//  Undefined: strict dcache priority; no counter logic synthesised.
// STRUCTURE
//  cpu_types_pkg: ramstate_t (existing), new arb_state_t enum {IDLE, IGRANT, DGRANT}, word_t used for all 32-bit buses.
//  One sub-module: arb_starve_counter (saturating counter + force_i flag), instantiated only under MEMARB_STARVE_GUARD_EN.
//  Top holds FSM, burst counter and output mux.
// TESTING
//  Reset: nRST=0 with iREN=dREN=1 -> iwait=dwait=1, ramREN=ramWEN=0, ramaddr=0.
//  iREN=1 iaddr=0x0040 alone, RAM gives ACCESS 2 cycles after grant -> ramREN=1 ramaddr=0x0040, iwait=0 and iload=ramload only that cycle.
//  iREN and dREN (daddr=0x1000) both high in IDLE -> DGRANT first; icache served only after dcache burst of 2 words (0x1000, 0x1004).
//  dWEN=1 daddr=0x2000 dstore=0xDEADBEEF -> ramWEN=1 ramstore=0xDEADBEEF; dREN=dWEN=1 -> ramREN=0.
//  nRST pulsed after first ACCESS of 2-word burst -> all outputs reset values; after release arbitration restarts from IDLE.
//  MEMARB_STARVE_GUARD_EN, STARVE_LIMIT=4, dREN and iREN held high -> 4 dcache grants, then IGRANT, then dcache resumes.

Source files
------------

// File: rtl/memory_arbiter_pkg.sv
// Shared types for the cache/RAM arbiter: RAM handshake state, arbiter FSM state, bus word.
// Also holds the default burst/starvation limits and a counter-width helper.
package memory_arbiter_pkg;

  typedef logic [31:0] word_t;

  typedef enum logic [1:0] {
    FREE   = 2'd0,
    BUSY   = 2'd1,
    ACCESS = 2'd2,
    ERROR  = 2'd3
  } ramstate_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    IGRANT = 2'd1,
    DGRANT = 2'd2
  } arb_state_t;

  localparam int unsigned BURST_MAX_DEFAULT    = 2;
  localparam int unsigned STARVE_LIMIT_DEFAULT = 4;

  // Bits needed to count from 0 up to and including maxVal.
  function automatic int unsigned ctrWidth(input int unsigned maxVal);
    return (maxVal < 1) ? 1 : $clog2(maxVal + 1);
  endfunction

endpackage

// File: rtl/memory_arbiter_if.sv
// Bundle of icache, dcache and RAM-side signals around the memory arbiter.
// slave = arbiter view; master = caches plus RAM model view.
interface memory_arbiter_if;
  import memory_arbiter_pkg::*;

  logic      iREN;
  word_t     iaddr;
  logic      iwait;
  word_t     iload;

  logic      dREN;
  logic      dWEN;
  word_t     daddr;
  word_t     dstore;
  logic      dwait;
  word_t     dload;

  logic      ramREN;
  logic      ramWEN;
  word_t     ramaddr;
  word_t     ramstore;
  word_t     ramload;
  ramstate_t ramstate;

  modport slave (
    input  iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
    output iwait, iload, dwait, dload, ramREN, ramWEN, ramaddr, ramstore
  );

  modport master (
    output iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
    input  iwait, iload, dwait, dload, ramREN, ramWEN, ramaddr, ramstore
  );

endinterface

// File: rtl/arb_starve_counter.sv
// Counts consecutive dcache grants taken while the icache was waiting; raises o_forceI at the limit.
// Only compiled when MEMARB_STARVE_GUARD_EN is defined.
`ifdef MEMARB_STARVE_GUARD_EN
module arb_starve_counter
  import memory_arbiter_pkg::*;
#(
  parameter int unsigned STARVE_LIMIT = STARVE_LIMIT_DEFAULT
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_dGrant,
  input  logic i_iGrant,
  input  logic i_iReq,
  output logic o_forceI
);

  localparam int unsigned CW = ctrWidth(STARVE_LIMIT);
  localparam logic [CW-1:0] LIMIT = CW'(STARVE_LIMIT);

  logic [CW-1:0] r_count;

  // Any icache service, or the icache no longer waiting, ends the starvation run.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_count <= '0;
    end else if (i_iGrant || !i_iReq) begin
      r_count <= '0;
    end else if (i_dGrant && (r_count < LIMIT)) begin
      r_count <= r_count + CW'(1);
    end
  end

  assign o_forceI = (r_count >= LIMIT);

endmodule
`endif

// File: rtl/memory_arbiter.sv
// Arbitrates the single-port RAM between icache and dcache, holding grants across short bursts.
// Define MEMARB_STARVE_GUARD_EN to let a starved icache win after STARVE_LIMIT dcache grants.
module memory_arbiter
  import memory_arbiter_pkg::*;
#(
  parameter int unsigned BURST_MAX = BURST_MAX_DEFAULT
`ifdef MEMARB_STARVE_GUARD_EN
  ,
  parameter int unsigned STARVE_LIMIT = STARVE_LIMIT_DEFAULT
`endif
) (
  input  logic CLK,
  input  logic nRST,
  memory_arbiter_if.slave bus
);

  localparam int unsigned BW = ctrWidth(BURST_MAX);
  localparam logic [BW-1:0] BURST_LIMIT = BW'(BURST_MAX);

  arb_state_t    r_state;
  arb_state_t    w_stateNext;
  logic [BW-1:0] r_burst;
  logic [BW-1:0] w_burstNext;
  logic [BW-1:0] w_burstInc;

  logic  w_iReq;
  logic  w_dReq;
  logic  w_access;
  logic  w_iDone;
  logic  w_dDone;
  logic  w_ownReq;
  logic  w_ownDone;
  logic  w_forceI;

  logic  w_ramREN;
  logic  w_ramWEN;
  word_t w_ramaddr;
  word_t w_ramstore;

  assign w_iReq   = bus.iREN;
  assign w_dReq   = bus.dREN | bus.dWEN;
  assign w_access = (bus.ramstate == ACCESS);
  assign w_iDone  = (r_state == IGRANT) && w_iReq && w_access;
  assign w_dDone  = (r_state == DGRANT) && w_dReq && w_access;

  assign w_ownReq  = ((r_state == IGRANT) && w_iReq) || ((r_state == DGRANT) && w_dReq);
  assign w_ownDone = w_iDone | w_dDone;

`ifdef MEMARB_STARVE_GUARD_EN
  logic w_dGrant;
  logic w_iGrant;

  assign w_dGrant = (r_state == IDLE) && (w_stateNext == DGRANT);
  assign w_iGrant = (r_state == IGRANT);

  arb_starve_counter #(
    .STARVE_LIMIT (STARVE_LIMIT)
  ) u_starve (
    .i_clk    (CLK),
    .i_rst_n  (nRST),
    .i_dGrant (w_dGrant),
    .i_iGrant (w_iGrant),
    .i_iReq   (w_iReq),
    .o_forceI (w_forceI)
  );
`else
  assign w_forceI = 1'b0;
`endif

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_state <= IDLE;
      r_burst <= '0;
    end else begin
      r_state <= w_stateNext;
      r_burst <= w_burstNext;
    end
  end

  // A grant ends when the burst fills or the owner stops asking; BUSY/FREE/ERROR just hold.
  always_comb begin
    w_stateNext = r_state;
    w_burstNext = r_burst;
    w_burstInc  = r_burst + BW'(1);
    unique case (r_state)
      IDLE: begin
        w_burstNext = '0;
        if (w_forceI && w_iReq) begin
          w_stateNext = IGRANT;
        end else if (w_dReq) begin
          w_stateNext = DGRANT;
        end else if (w_iReq) begin
          w_stateNext = IGRANT;
        end
      end
      IGRANT, DGRANT: begin
        if (w_ownDone) begin
          if (w_ownReq && (w_burstInc < BURST_LIMIT)) begin
            w_burstNext = w_burstInc;
          end else begin
            w_stateNext = IDLE;
            w_burstNext = '0;
          end
        end else if (!w_ownReq) begin
          w_stateNext = IDLE;
          w_burstNext = '0;
        end
      end
      default: begin
        w_stateNext = IDLE;
        w_burstNext = '0;
      end
    endcase
  end

  // A simultaneous dcache read and write is treated as the write.
  always_comb begin
    w_ramREN   = 1'b0;
    w_ramWEN   = 1'b0;
    w_ramaddr  = '0;
    w_ramstore = '0;
    unique case (r_state)
      IGRANT: begin
        w_ramaddr = bus.iaddr;
        w_ramREN  = bus.iREN;
      end
      DGRANT: begin
        w_ramaddr  = bus.daddr;
        w_ramstore = bus.dstore;
        w_ramWEN   = bus.dWEN;
        w_ramREN   = bus.dREN & ~bus.dWEN;
      end
      default: begin
        w_ramREN = 1'b0;
      end
    endcase
  end

  assign bus.ramREN   = w_ramREN;
  assign bus.ramWEN   = w_ramWEN;
  assign bus.ramaddr  = w_ramaddr;
  assign bus.ramstore = w_ramstore;

  assign bus.iwait = ~w_iDone;
  assign bus.dwait = ~w_dDone;
  assign bus.iload = w_iDone ? bus.ramload : '0;
  assign bus.dload = w_dDone ? bus.ramload : '0;

endmodule

// File: tb/tb_memory_arbiter.sv
// Directed self-checking bench for memory_arbiter; the starvation scenario runs only with MEMARB_STARVE_GUARD_EN.
module tb_memory_arbiter;
  import memory_arbiter_pkg::*;

  logic CLK = 1'b0;
  logic nRST;
  int   errors = 0;
  int   checks = 0;

  memory_arbiter_if bus ();

  memory_arbiter dut (
    .CLK  (CLK),
    .nRST (nRST),
    .bus  (bus)
  );

  always #5 CLK = ~CLK;

  task automatic applyStimulus(input logic iREN, input word_t iaddr, input logic dREN,
                               input logic dWEN, input word_t daddr, input word_t dstore,
                               input ramstate_t rs, input word_t rload);
    bus.iREN     = iREN;
    bus.iaddr    = iaddr;
    bus.dREN     = dREN;
    bus.dWEN     = dWEN;
    bus.daddr    = daddr;
    bus.dstore   = dstore;
    bus.ramstate = rs;
    bus.ramload  = rload;
  endtask

  task automatic nextCycle();
    @(posedge CLK);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  task automatic test_reset();
    applyStimulus(1'b1, 32'h40, 1'b1, 1'b0, 32'h1000, 32'h0, ACCESS, 32'h12345678);
    nRST = 1'b1;
    #2;
    nRST = 1'b0;
    repeat (2) @(posedge CLK);
    #1; settle();
    checks++; if (bus.iwait !== 1'b1) begin errors++; $display("[TB] FAIL rst_iwait got=%0b want=1", bus.iwait); end
    checks++; if (bus.dwait !== 1'b1) begin errors++; $display("[TB] FAIL rst_dwait got=%0b want=1", bus.dwait); end
    checks++; if (bus.ramREN !== 1'b0) begin errors++; $display("[TB] FAIL rst_ramREN got=%0b want=0", bus.ramREN); end
    checks++; if (bus.ramWEN !== 1'b0) begin errors++; $display("[TB] FAIL rst_ramWEN got=%0b want=0", bus.ramWEN); end
    checks++; if (bus.ramaddr !== 32'h0) begin errors++; $display("[TB] FAIL rst_ramaddr got=%h want=0", bus.ramaddr); end
    checks++; if (bus.ramstore !== 32'h0) begin errors++; $display("[TB] FAIL rst_ramstore got=%h want=0", bus.ramstore); end
    checks++; if (bus.iload !== 32'h0) begin errors++; $display("[TB] FAIL rst_iload got=%h want=0", bus.iload); end
    checks++; if (bus.dload !== 32'h0) begin errors++; $display("[TB] FAIL rst_dload got=%h want=0", bus.dload); end
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, FREE, 32'h0);
    nRST = 1'b1;
    nextCycle(); settle();
    checks++; if (bus.ramREN !== 1'b0) begin errors++; $display("[TB] FAIL rst_release_idle got=%0b want=0", bus.ramREN); end
    nextCycle();
  endtask

  task automatic test_icache_read();
    applyStimulus(1'b1, 32'h40, 1'b0, 1'b0, 32'h0, 32'h0, FREE, 32'h0);
    settle();
    checks++; if (bus.ramREN !== 1'b0) begin errors++; $display("[TB] FAIL ird_latency_ramREN got=%0b want=0", bus.ramREN); end
    checks++; if (bus.iwait !== 1'b1) begin errors++; $display("[TB] FAIL ird_latency_iwait got=%0b want=1", bus.iwait); end
    nextCycle();
    bus.ramstate = BUSY; settle();
    checks++; if (bus.ramREN !== 1'b1) begin errors++; $display("[TB] FAIL ird_grant_ramREN got=%0b want=1", bus.ramREN); end
    checks++; if (bus.ramaddr !== 32'h40) begin errors++; $display("[TB] FAIL ird_grant_ramaddr got=%h want=00000040", bus.ramaddr); end
    checks++; if (bus.iwait !== 1'b1) begin errors++; $display("[TB] FAIL ird_busy_iwait got=%0b want=1", bus.iwait); end
    checks++; if (bus.iload !== 32'h0) begin errors++; $display("[TB] FAIL ird_busy_iload got=%h want=0", bus.iload); end
    nextCycle(); settle();
    checks++; if (bus.iwait !== 1'b1) begin errors++; $display("[TB] FAIL ird_busy2_iwait got=%0b want=1", bus.iwait); end
    nextCycle();
    bus.ramstate = ACCESS; bus.ramload = 32'hCAFE0040; settle();
    checks++; if (bus.iwait !== 1'b0) begin errors++; $display("[TB] FAIL ird_access_iwait got=%0b want=0", bus.iwait); end
    checks++; if (bus.iload !== 32'hCAFE0040) begin errors++; $display("[TB] FAIL ird_access_iload got=%h want=cafe0040", bus.iload); end
    checks++; if (bus.dwait !== 1'b1) begin errors++; $display("[TB] FAIL ird_access_dwait got=%0b want=1", bus.dwait); end
    checks++; if (bus.dload !== 32'h0) begin errors++; $display("[TB] FAIL ird_access_dload got=%h want=0", bus.dload); end
    nextCycle();
    bus.iREN = 1'b0; bus.ramstate = FREE; settle();
    checks++; if (bus.iwait !== 1'b1) begin errors++; $display("[TB] FAIL ird_after_iwait got=%0b want=1", bus.iwait); end
    checks++; if (bus.iload !== 32'h0) begin errors++; $display("[TB] FAIL ird_after_iload got=%h want=0", bus.iload); end
    checks++; if (bus.ramREN !== 1'b0) begin errors++; $display("[TB] FAIL ird_drop_ramREN got=%0b want=0", bus.ramREN); end
    nextCycle(); settle();
    checks++; if (bus.ramaddr !== 32'h0) begin errors++; $display("[TB] FAIL ird_idle_ramaddr got=%h want=0", bus.ramaddr); end
    nextCycle();
  endtask

  task automatic test_priority();
    applyStimulus(1'b1, 32'h80, 1'b1, 1'b0, 32'h1000, 32'h0, FREE, 32'h0);
    settle();
    checks++; if (bus.ramREN !== 1'b0) begin errors++; $display("[TB] FAIL pri_idle_ramREN got=%0b want=0", bus.ramREN); end
    nextCycle(); settle();
    checks++; if (bus.ramaddr !== 32'h1000) begin errors++; $display("[TB] FAIL pri_dfirst_ramaddr got=%h want=00001000", bus.ramaddr); end
    checks++; if (bus.ramREN !== 1'b1) begin errors++; $display("[TB] FAIL pri_dfirst_ramREN got=%0b want=1", bus.ramREN); end
    bus.ramstate = ACCESS; bus.ramload = 32'h11111111; settle();
    checks++; if (bus.dwait !== 1'b0) begin errors++; $display("[TB] FAIL pri_w0_dwait got=%0b want=0", bus.dwait); end
    checks++; if (bus.dload !== 32'h11111111) begin errors++; $display("[TB] FAIL pri_w0_dload got=%h want=11111111", bus.dload); end
    checks++; if (bus.iwait !== 1'b1) begin errors++; $display("[TB] FAIL pri_w0_iwait got=%0b want=1", bus.iwait); end
    checks++; if (bus.iload !== 32'h0) begin errors++; $display("[TB] FAIL pri_w0_iload got=%h want=0", bus.iload); end
    nextCycle();
    bus.daddr = 32'h1004; bus.ramload = 32'h22222222; settle();
    checks++; if (bus.ramaddr !== 32'h1004) begin errors++; $display("[TB] FAIL pri_w1_ramaddr got=%h want=00001004", bus.ramaddr); end
    checks++; if (bus.dwait !== 1'b0) begin errors++; $display("[TB] FAIL pri_w1_dwait got=%0b want=0", bus.dwait); end
    checks++; if (bus.dload !== 32'h22222222) begin errors++; $display("[TB] FAIL pri_w1_dload got=%h want=22222222", bus.dload); end
    nextCycle();
    bus.dREN = 1'b0; bus.ramstate = FREE; settle();
    checks++; if (bus.ramREN !== 1'b0) begin errors++; $display("[TB] FAIL pri_burst_end_ramREN got=%0b want=0", bus.ramREN); end
    checks++; if (bus.iwait !== 1'b1) begin errors++; $display("[TB] FAIL pri_burst_end_iwait got=%0b want=1", bus.iwait); end
    nextCycle();
    bus.ramstate = ACCESS; bus.ramload = 32'h33333333; settle();
    checks++; if (bus.ramaddr !== 32'h80) begin errors++; $display("[TB] FAIL pri_i_ramaddr got=%h want=00000080", bus.ramaddr); end
    checks++; if (bus.iwait !== 1'b0) begin errors++; $display("[TB] FAIL pri_i_iwait got=%0b want=0", bus.iwait); end
    checks++; if (bus.iload !== 32'h33333333) begin errors++; $display("[TB] FAIL pri_i_iload got=%h want=33333333", bus.iload); end
    checks++; if (bus.dwait !== 1'b1) begin errors++; $display("[TB] FAIL pri_i_dwait got=%0b want=1", bus.dwait); end
    nextCycle();
    bus.iREN = 1'b0; bus.ramstate = FREE;
    nextCycle();
  endtask

  task automatic test_write();
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b1, 32'h2000, 32'hDEADBEEF, FREE, 32'h0);
    settle();
    checks++; if (bus.ramWEN !== 1'b0) begin errors++; $display("[TB] FAIL wr_idle_ramWEN got=%0b want=0", bus.ramWEN); end
    nextCycle();
    bus.ramstate = ERROR; settle();
    checks++; if (bus.ramWEN !== 1'b1) begin errors++; $display("[TB] FAIL wr_ramWEN got=%0b want=1", bus.ramWEN); end
    checks++; if (bus.ramstore !== 32'hDEADBEEF) begin errors++; $display("[TB] FAIL wr_ramstore got=%h want=deadbeef", bus.ramstore); end
    checks++; if (bus.ramaddr !== 32'h2000) begin errors++; $display("[TB] FAIL wr_ramaddr got=%h want=00002000", bus.ramaddr); end
    checks++; if (bus.ramREN !== 1'b0) begin errors++; $display("[TB] FAIL wr_ramREN got=%0b want=0", bus.ramREN); end
    checks++; if (bus.dwait !== 1'b1) begin errors++; $display("[TB] FAIL wr_error_dwait got=%0b want=1", bus.dwait); end
    nextCycle();
    bus.dREN = 1'b1; bus.ramstate = ACCESS; settle();
    checks++; if (bus.ramREN !== 1'b0) begin errors++; $display("[TB] FAIL wr_rw_ramREN got=%0b want=0", bus.ramREN); end
    checks++; if (bus.ramWEN !== 1'b1) begin errors++; $display("[TB] FAIL wr_rw_ramWEN got=%0b want=1", bus.ramWEN); end
    checks++; if (bus.dwait !== 1'b0) begin errors++; $display("[TB] FAIL wr_rw_dwait got=%0b want=0", bus.dwait); end
    nextCycle();
    bus.dREN = 1'b0; bus.dWEN = 1'b0; bus.ramstate = FREE; settle();
    checks++; if (bus.ramWEN !== 1'b0) begin errors++; $display("[TB] FAIL wr_drop_ramWEN got=%0b want=0", bus.ramWEN); end
    checks++; if (bus.dwait !== 1'b1) begin errors++; $display("[TB] FAIL wr_drop_dwait got=%0b want=1", bus.dwait); end
    nextCycle(); settle();
    checks++; if (bus.ramstore !== 32'h0) begin errors++; $display("[TB] FAIL wr_idle_ramstore got=%h want=0", bus.ramstore); end
    nextCycle();
  endtask

  task automatic test_back_to_back();
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 32'h5000, 32'h0, ACCESS, 32'h5A5A5A5A);
    settle();
    checks++; if (bus.ramREN !== 1'b0) begin errors++; $display("[TB] FAIL b2b_idle_ramREN got=%0b want=0", bus.ramREN); end
    nextCycle(); settle();
    checks++; if (bus.dwait !== 1'b0) begin errors++; $display("[TB] FAIL b2b_w0_dwait got=%0b want=0", bus.dwait); end
    nextCycle(); settle();
    checks++; if (bus.dwait !== 1'b0) begin errors++; $display("[TB] FAIL b2b_w1_dwait got=%0b want=0", bus.dwait); end
    nextCycle(); settle();
    checks++; if (bus.ramREN !== 1'b0) begin errors++; $display("[TB] FAIL b2b_rearb_ramREN got=%0b want=0", bus.ramREN); end
    checks++; if (bus.dwait !== 1'b1) begin errors++; $display("[TB] FAIL b2b_rearb_dwait got=%0b want=1", bus.dwait); end
    nextCycle(); settle();
    checks++; if (bus.ramREN !== 1'b1) begin errors++; $display("[TB] FAIL b2b_regrant_ramREN got=%0b want=1", bus.ramREN); end
    bus.dREN = 1'b0; bus.ramstate = FREE;
    nextCycle();
    nextCycle();
  endtask

  task automatic test_reset_midburst();
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 32'h3000, 32'h0, FREE, 32'h0);
    nextCycle();
    bus.ramstate = ACCESS; bus.ramload = 32'h44444444; settle();
    checks++; if (bus.dwait !== 1'b0) begin errors++; $display("[TB] FAIL mrst_w0_dwait got=%0b want=0", bus.dwait); end
    nextCycle();
    bus.ramstate = BUSY; settle();
    checks++; if (bus.ramREN !== 1'b1) begin errors++; $display("[TB] FAIL mrst_held_ramREN got=%0b want=1", bus.ramREN); end
    nRST = 1'b0; bus.ramstate = ACCESS; #1;
    checks++; if (bus.ramREN !== 1'b0) begin errors++; $display("[TB] FAIL mrst_ramREN got=%0b want=0", bus.ramREN); end
    checks++; if (bus.ramaddr !== 32'h0) begin errors++; $display("[TB] FAIL mrst_ramaddr got=%h want=0", bus.ramaddr); end
    checks++; if (bus.dwait !== 1'b1) begin errors++; $display("[TB] FAIL mrst_dwait got=%0b want=1", bus.dwait); end
    checks++; if (bus.dload !== 32'h0) begin errors++; $display("[TB] FAIL mrst_dload got=%h want=0", bus.dload); end
    nextCycle();
    nextCycle();
    bus.ramstate = FREE; nRST = 1'b1; settle();
    checks++; if (bus.ramREN !== 1'b0) begin errors++; $display("[TB] FAIL mrst_restart_idle got=%0b want=0", bus.ramREN); end
    nextCycle();
    bus.ramstate = ACCESS; bus.ramload = 32'h55555555; settle();
    checks++; if (bus.ramaddr !== 32'h3000) begin errors++; $display("[TB] FAIL mrst_regrant_ramaddr got=%h want=00003000", bus.ramaddr); end
    checks++; if (bus.dwait !== 1'b0) begin errors++; $display("[TB] FAIL mrst_regrant_dwait got=%0b want=0", bus.dwait); end
    nextCycle();
    bus.ramload = 32'h66666666; settle();
    checks++; if (bus.ramREN !== 1'b1) begin errors++; $display("[TB] FAIL mrst_fresh_burst_ramREN got=%0b want=1", bus.ramREN); end
    checks++; if (bus.dload !== 32'h66666666) begin errors++; $display("[TB] FAIL mrst_fresh_burst_dload got=%h want=66666666", bus.dload); end
    nextCycle();
    bus.dREN = 1'b0; bus.ramstate = FREE;
    nextCycle();
    nextCycle();
  endtask

`ifdef MEMARB_STARVE_GUARD_EN
  task automatic test_starve_guard();
    logic [1:0] grants [6];
    logic [1:0] expGrants [6];
    logic [1:0] prevOwner;
    logic [1:0] owner;
    int         nGrants;
    expGrants = '{2'd2, 2'd2, 2'd2, 2'd2, 2'd1, 2'd2};
    grants    = '{default: 2'd0};
    prevOwner = 2'd0;
    nGrants   = 0;
    applyStimulus(1'b1, 32'hA0, 1'b1, 1'b0, 32'hB0, 32'h0, ACCESS, 32'h77777777);
    for (int cyc = 0; cyc < 60 && nGrants < 6; cyc++) begin
      settle();
      owner = 2'd0;
      if (bus.ramREN === 1'b1 && bus.ramaddr === 32'hB0) owner = 2'd2;
      else if (bus.ramREN === 1'b1 && bus.ramaddr === 32'hA0) owner = 2'd1;
      if (owner != 2'd0 && owner != prevOwner) begin
        grants[nGrants] = owner;
        nGrants++;
      end
      prevOwner = owner;
      nextCycle();
    end
    checks++; if (nGrants != 6) begin errors++; $display("[TB] FAIL starve_grant_count got=%0d want=6", nGrants); end
    for (int k = 0; k < 6; k++) begin
      checks++; if (grants[k] !== expGrants[k]) begin errors++; $display("[TB] FAIL starve_grant_%0d got=%0d want=%0d (1=icache 2=dcache)", k, grants[k], expGrants[k]); end
    end
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, FREE, 32'h0);
    nextCycle();
    nextCycle();
  endtask
`endif

  initial begin
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, FREE, 32'h0);
    test_reset();
    test_icache_read();
    test_priority();
    test_write();
    test_back_to_back();
    test_reset_midburst();
`ifdef MEMARB_STARVE_GUARD_EN
    test_starve_guard();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
